// File: rtl/fifo_word_packer_if.sv
// Bundle between the packer, its source fifo (ren/dout/empty, 1-cycle read latency)
// and the downstream valid/ready word stream; master is the packer side.
interface fifo_word_packer_if #(
  parameter int IN_WIDTH  = 8,
  parameter int PACK      = 8,
  parameter int OUT_WIDTH = IN_WIDTH * PACK,
  parameter int CNT_WIDTH = $clog2(PACK + 1)
);
  logic                 fifo_empty;
  logic                 fifo_ren;
  logic [IN_WIDTH-1:0]  fifo_dout;
  logic                 flush;
  logic                 out_valid;
  logic                 out_ready;
  logic [OUT_WIDTH-1:0] out_data;
  logic [CNT_WIDTH-1:0] out_count;
  logic                 out_last;
  logic                 done;

  modport master (
    input  fifo_empty, fifo_dout, flush, out_ready,
    output fifo_ren, out_valid, out_data, out_count, out_last, done
  );

  modport slave (
    output fifo_empty, fifo_dout, flush, out_ready,
    input  fifo_ren, out_valid, out_data, out_count, out_last, done
  );
endinterface

// File: rtl/fifo_word_packer.sv
// Drains a fifo and packs PACK elements (lane 0 first) into one word; flush closes with a partial last word.
// Word valid PACK+1 cycles after the first read; out_ready low holds the word stable and stops all reads.
module fifo_word_packer #(
  parameter int IN_WIDTH  = 8,
  parameter int PACK      = 8,
  parameter int OUT_WIDTH = IN_WIDTH * PACK,
  parameter int CNT_WIDTH = $clog2(PACK + 1)
) (
  input  logic               clk,
  input  logic               rst,
  fifo_word_packer_if.master bus
);

  typedef enum logic {FILL = 1'b0, EMIT = 1'b1} state_t;

  state_t               state_q, state_d;
  logic [OUT_WIDTH-1:0] lanes_q, lanes_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 rd_pend_q, rd_pend_d;
  logic                 flush_pend_q, flush_pend_d;
  logic                 last_q, last_d;
  logic                 done_q, done_d;

  logic                 fifo_ren;
  logic                 out_valid;
  logic                 room;
  logic                 fill_full;
  logic                 close_now;

  // In-flight reads count against the word so we never over-fetch past PACK.
  assign room      = (count_q + CNT_WIDTH'(rd_pend_q)) < CNT_WIDTH'(PACK);
  assign fill_full = (count_d == CNT_WIDTH'(PACK));
  assign close_now = flush_pend_q && bus.fifo_empty && !rd_pend_q;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:    if (fill_full || close_now) state_d = EMIT;
      EMIT:    if (bus.out_ready) state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  // Output logic
  always_comb begin
    fifo_ren  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      FILL:    fifo_ren = !rst && !bus.fifo_empty && room;
      EMIT:    out_valid = 1'b1;
      default: begin
        fifo_ren  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  // Datapath next values
  always_comb begin
    lanes_d      = lanes_q;
    count_d      = count_q;
    rd_pend_d    = fifo_ren;
    flush_pend_d = flush_pend_q;
    last_d       = last_q;
    done_d       = 1'b0;

    if (bus.flush) flush_pend_d = 1'b1;

    if (state_q == FILL) begin
      if (rd_pend_q) begin
        for (int k = 0; k < PACK; k++) begin
          if (count_q == CNT_WIDTH'(k)) lanes_d[k*IN_WIDTH +: IN_WIDTH] = bus.fifo_dout;
        end
        count_d = count_q + CNT_WIDTH'(1);
      end
      // A full word only closes the stream if nothing is left to read behind it.
      if (fill_full || close_now) last_d = flush_pend_q && bus.fifo_empty && !fifo_ren;
    end else if (bus.out_ready) begin
      lanes_d = '0;
      count_d = '0;
      last_d  = 1'b0;
      if (last_q) begin
        flush_pend_d = 1'b0;
        done_d       = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lanes_q      <= '0;
      count_q      <= '0;
      rd_pend_q    <= 1'b0;
      flush_pend_q <= 1'b0;
      last_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      lanes_q      <= lanes_d;
      count_q      <= count_d;
      rd_pend_q    <= rd_pend_d;
      flush_pend_q <= flush_pend_d;
      last_q       <= last_d;
      done_q       <= done_d;
    end
  end

  assign bus.fifo_ren  = fifo_ren;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = lanes_q;
  assign bus.out_count = count_q;
  assign bus.out_last  = last_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_fifo_word_packer.sv
// Directed bench for fifo_word_packer: behavioural fifo source, word capture monitor, hand-computed expectations.
module tb_fifo_word_packer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_word_packer_if #(.IN_WIDTH(8), .PACK(8)) bus ();

  fifo_word_packer #(.IN_WIDTH(8), .PACK(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // fifo source: 1-cycle read latency, reset discards everything up to rd_base
  logic [7:0] mem [0:255];
  int         wr_ptr = 0;
  int         rd_base = 0;
  int         rd_ptr = 0;
  logic [7:0] fdout = 8'h00;
  logic       tog = 1'b0;
  logic       toggle_en = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= rd_base;
      fdout  <= 8'h00;
      tog    <= 1'b0;
    end else begin
      tog <= ~tog;
      if (bus.fifo_ren) begin
        fdout  <= mem[rd_ptr[7:0]];
        rd_ptr <= rd_ptr + 1;
      end
    end
  end

  assign bus.fifo_dout  = fdout;
  assign bus.fifo_empty = (rd_ptr == wr_ptr) || (toggle_en && tog);

  // monitor, sampled on the falling edge
  int          cyc = 0;
  int          ren_cnt = 0, ren_rise_cyc = 0, ren_last_cyc = 0;
  int          valid_rise_cyc = 0, last_acc_cyc = 0, done_cyc = 0, done_cnt = 0;
  int          viol_empty = 0, viol_emit = 0, stab_viol = 0;
  int          words_n = 0;
  logic [63:0] w_data [0:63];
  logic [3:0]  w_cnt  [0:63];
  logic        w_last [0:63];
  logic        prev_ren = 1'b0, prev_valid = 1'b0, prev_rdy = 1'b0;
  logic [68:0] prev_word = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.fifo_ren) begin
        ren_cnt      <= ren_cnt + 1;
        ren_last_cyc <= cyc;
        if (!prev_ren) ren_rise_cyc <= cyc;
      end
      if (bus.fifo_ren && bus.fifo_empty) viol_empty <= viol_empty + 1;
      if (bus.fifo_ren && bus.out_valid) viol_emit <= viol_emit + 1;
      if (bus.out_valid && !prev_valid) valid_rise_cyc <= cyc;
      if (prev_valid && !prev_rdy &&
          (!bus.out_valid || {bus.out_data, bus.out_count, bus.out_last} != prev_word))
        stab_viol <= stab_viol + 1;
      if (bus.out_valid && bus.out_ready) begin
        w_data[words_n[5:0]] <= bus.out_data;
        w_cnt[words_n[5:0]]  <= bus.out_count;
        w_last[words_n[5:0]] <= bus.out_last;
        words_n              <= words_n + 1;
        if (bus.out_last) last_acc_cyc <= cyc;
      end
      if (bus.done) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= cyc;
      end
    end
    prev_ren   <= bus.fifo_ren;
    prev_valid <= bus.out_valid;
    prev_rdy   <= bus.out_ready;
    prev_word  <= {bus.out_data, bus.out_count, bus.out_last};
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [7:0] v);
    mem[wr_ptr[7:0]] = v;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic wait_words(input int target, input int budget);
    int k = 0;
    while (words_n < target && k < budget) begin
      tick(1);
      k++;
    end
  endtask

  task automatic pulse_flush();
    bus.flush = 1'b1;
    tick(1);
    bus.flush = 1'b0;
  endtask

  task automatic check_word(input string tag, input int idx, input logic [63:0] d,
                            input logic [3:0] c, input logic l);
    check({tag, "_data"},  w_data[idx[5:0]], d);
    check({tag, "_count"}, 64'(w_cnt[idx[5:0]]), 64'(c));
    check({tag, "_last"},  64'(w_last[idx[5:0]]), 64'(l));
  endtask

  int wb, db, rb;

  initial begin
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;

    // reset state
    tick(2);
    check("rst_valid", 64'(bus.out_valid), 64'd0);
    check("rst_data",  bus.out_data, 64'd0);
    check("rst_count", 64'(bus.out_count), 64'd0);
    check("rst_last",  64'(bus.out_last), 64'd0);
    check("rst_done",  64'(bus.done), 64'd0);
    check("rst_ren",   64'(bus.fifo_ren), 64'd0);
    rst = 1'b0;
    tick(2);

    // T1: full word, timing
    bus.out_ready = 1'b1;
    wb = words_n; rb = ren_cnt;
    for (int i = 1; i <= 8; i++) push(8'(i));
    wait_words(wb + 1, 40);
    tick(3);
    check("t1_nwords", 64'(words_n - wb), 64'd1);
    check_word("t1", wb, 64'h0807060504030201, 4'd8, 1'b0);
    check("t1_valid_lat", 64'(valid_rise_cyc - ren_rise_cyc), 64'd9);
    check("t1_ren_cnt",   64'(ren_cnt - rb), 64'd8);
    check("t1_ren_span",  64'(ren_last_cyc - ren_rise_cyc), 64'd7);

    // T2: two words, 5-cycle stall on the first
    bus.out_ready = 1'b0;
    wb = words_n;
    for (int i = 9; i <= 24; i++) push(8'(i - 8));
    for (int k = 0; k < 40 && !bus.out_valid; k++) tick(1);
    check("t2_valid", 64'(bus.out_valid), 64'd1);
    rb = ren_cnt;
    tick(5);
    check("t2_stall_ren", 64'(ren_cnt - rb), 64'd0);
    check("t2_stall_data", bus.out_data, 64'h0807060504030201);
    bus.out_ready = 1'b1;
    wait_words(wb + 2, 40);
    tick(3);
    check("t2_nwords", 64'(words_n - wb), 64'd2);
    check_word("t2_w0", wb, 64'h0807060504030201, 4'd8, 1'b0);
    check_word("t2_w1", wb + 1, 64'h100F0E0D0C0B0A09, 4'd8, 1'b0);

    // T3: partial word on flush
    wb = words_n; db = done_cnt;
    push(8'hAA); push(8'hBB); push(8'hCC);
    tick(1);
    pulse_flush();
    wait_words(wb + 1, 40);
    tick(3);
    check("t3_nwords", 64'(words_n - wb), 64'd1);
    check_word("t3", wb, 64'h0000000000CCBBAA, 4'd3, 1'b1);
    check("t3_done_cnt", 64'(done_cnt - db), 64'd1);
    check("t3_done_lat", 64'(done_cyc - last_acc_cyc), 64'd1);

    // T4: flush with nothing buffered
    wb = words_n; db = done_cnt;
    pulse_flush();
    wait_words(wb + 1, 40);
    tick(3);
    check("t4_nwords", 64'(words_n - wb), 64'd1);
    check_word("t4", wb, 64'h0, 4'd0, 1'b1);
    check("t4_done_cnt", 64'(done_cnt - db), 64'd1);

    // T5: exactly one full word then flush: no trailing empty word
    wb = words_n; db = done_cnt;
    for (int i = 0; i < 8; i++) push(8'h11 + 8'(i));
    tick(1);
    pulse_flush();
    wait_words(wb + 1, 40);
    tick(20);
    check("t5_nwords", 64'(words_n - wb), 64'd1);
    check_word("t5", wb, 64'h1817161514131211, 4'd8, 1'b1);
    check("t5_done_cnt", 64'(done_cnt - db), 64'd1);

    // T6: empty flag toggling every cycle
    toggle_en = 1'b1;
    wb = words_n;
    for (int i = 0; i < 16; i++) push(8'h21 + 8'(i));
    wait_words(wb + 2, 200);
    tick(3);
    toggle_en = 1'b0;
    check("t6_nwords", 64'(words_n - wb), 64'd2);
    check_word("t6_w0", wb, 64'h2827262524232221, 4'd8, 1'b0);
    check_word("t6_w1", wb + 1, 64'h302F2E2D2C2B2A29, 4'd8, 1'b0);
    check("t6_ren_empty", 64'(viol_empty), 64'd0);

    // T7: async reset with a read in flight
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(8'h41 + 8'(i));
    tick(3);
    check("t7_pre_count", 64'(bus.out_count), 64'd2);
    rd_base = wr_ptr;
    rst = 1'b1;
    #1;
    check("t7_rst_count", 64'(bus.out_count), 64'd0);
    check("t7_rst_data",  bus.out_data, 64'd0);
    check("t7_rst_valid", 64'(bus.out_valid), 64'd0);
    for (int i = 0; i < 8; i++) push(8'h51 + 8'(i));
    #1;
    check("t7_rst_ren", 64'(bus.fifo_ren), 64'd0);
    tick(2);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    wb = words_n;
    wait_words(wb + 1, 40);
    tick(3);
    check("t7_nwords", 64'(words_n - wb), 64'd1);
    check_word("t7", wb, 64'h5857565554535251, 4'd8, 1'b0);

    check("ren_in_emit", 64'(viol_emit), 64'd0);
    check("hold_stable", 64'(stab_viol), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
